// File: rtl/i2s_tx.sv
// I2S master transmitter: serialises stereo PCM pairs onto BCLK/WS/DATA from a
// one-pair holding register, repeating the last pair whenever the source falls behind.
module i2s_tx #(
   parameter int unsigned CLK_DIV   = 8,
   parameter int unsigned SAMPLE_W  = 16,
   parameter int unsigned SLOT_BITS = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                en,
   input  logic [SAMPLE_W-1:0] in_l,
   input  logic [SAMPLE_W-1:0] in_r,
   input  logic                in_valid,
   output logic                in_ready,
   output logic                i2s_bclk,
   output logic                i2s_ws,
   output logic                i2s_data,
   output logic                frame_start,
   output logic                underrun
);

   localparam int unsigned FRAME = 2 * SLOT_BITS;
   localparam int unsigned PW    = $clog2(FRAME);
   localparam int unsigned DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0]       div_q, div_d;
   logic [PW-1:0]       p_q, p_d;
   logic                bclk_q, bclk_d;
   logic                ws_q, ws_d;
   logic                data_q, data_d;
   logic                frame_start_q, frame_start_d;
   logic                underrun_q, underrun_d;
   logic                hold_full_q, hold_full_d;
   logic [SAMPLE_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic [SAMPLE_W-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;

   logic                fall, load, accept;
   logic [PW-1:0]       slot_pos;
   logic [SAMPLE_W-1:0] word, shifted;

   // Divider, frame position, frame load, handshake and output bit selection.
   always_comb begin
      div_d         = div_q;
      p_d           = p_q;
      bclk_d        = bclk_q;
      ws_d          = ws_q;
      data_d        = data_q;
      frame_start_d = 1'b0;
      underrun_d    = 1'b0;
      hold_full_d   = hold_full_q;
      hold_l_d      = hold_l_q;
      hold_r_d      = hold_r_q;
      sh_l_d        = sh_l_q;
      sh_r_d        = sh_r_q;
      fall          = 1'b0;
      load          = 1'b0;
      slot_pos      = '0;
      word          = '0;
      shifted       = '0;
      accept        = in_valid & ~hold_full_q;

      if (!en) begin
         div_d  = '0;
         bclk_d = 1'b0;
         ws_d   = 1'b0;
         data_d = 1'b0;
         p_d    = PW'(FRAME - 1);
      end else begin
         if (div_q == DW'(CLK_DIV - 1)) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
            fall   = bclk_q;
         end else begin
            div_d = div_q + DW'(1);
         end
         if (fall) begin
            if (p_q == PW'(FRAME - 1)) begin
               p_d  = '0;
               load = 1'b1;
            end else begin
               p_d = p_q + PW'(1);
            end
         end
      end

      // Load uses the pre-accept hold state, so an accept in the same clk waits a frame.
      if (load) begin
         frame_start_d = 1'b1;
         if (hold_full_q) begin
            sh_l_d      = hold_l_q;
            sh_r_d      = hold_r_q;
            hold_full_d = 1'b0;
         end else begin
            underrun_d = 1'b1;
         end
      end

      if (accept) begin
         hold_l_d    = in_l;
         hold_r_d    = in_r;
         hold_full_d = 1'b1;
      end

      // Shifting past the sample width yields the zero padding of long slots.
      if (fall) begin
         ws_d = (p_d >= PW'(SLOT_BITS - 1)) && (p_d <= PW'(FRAME - 2));
         if (p_d < PW'(SLOT_BITS)) begin
            slot_pos = p_d;
            word     = sh_l_d;
         end else begin
            slot_pos = p_d - PW'(SLOT_BITS);
            word     = sh_r_d;
         end
         shifted = word << slot_pos;
         data_d  = shifted[SAMPLE_W-1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q         <= '0;
         p_q           <= PW'(FRAME - 1);
         bclk_q        <= 1'b0;
         ws_q          <= 1'b0;
         data_q        <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
         hold_full_q   <= 1'b0;
         hold_l_q      <= '0;
         hold_r_q      <= '0;
         sh_l_q        <= '0;
         sh_r_q        <= '0;
      end else begin
         div_q         <= div_d;
         p_q           <= p_d;
         bclk_q        <= bclk_d;
         ws_q          <= ws_d;
         data_q        <= data_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
         hold_full_q   <= hold_full_d;
         hold_l_q      <= hold_l_d;
         hold_r_q      <= hold_r_d;
         sh_l_q        <= sh_l_d;
         sh_r_q        <= sh_r_d;
      end
   end

   assign in_ready    = ~hold_full_q;
   assign i2s_bclk    = bclk_q;
   assign i2s_ws      = ws_q;
   assign i2s_data    = data_q;
   assign frame_start = frame_start_q;
   assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: two instances (16-bit and 24-bit slots) checked cycle by cycle
// against an arithmetic frame model, plus an I2S receiver that recovers the sent words.
module tb_i2s_tx;

   localparam int CD = 2;
   localparam int SW = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        en = 1'b0;
   logic [15:0] in_l = '0, in_r = '0;
   logic [1:0]  vld = '0;
   logic        rdy [2];
   logic        bclk [2];
   logic        ws [2];
   logic        dat [2];
   logic        fs [2];
   logic        ur [2];

   i2s_tx #(.CLK_DIV(CD), .SAMPLE_W(SW), .SLOT_BITS(16)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .en(en), .in_l(in_l), .in_r(in_r),
      .in_valid(vld[0]), .in_ready(rdy[0]), .i2s_bclk(bclk[0]), .i2s_ws(ws[0]),
      .i2s_data(dat[0]), .frame_start(fs[0]), .underrun(ur[0]));

   i2s_tx #(.CLK_DIV(CD), .SAMPLE_W(SW), .SLOT_BITS(24)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .en(en), .in_l(in_l), .in_r(in_r),
      .in_valid(vld[1]), .in_ready(rdy[1]), .i2s_bclk(bclk[1]), .i2s_ws(ws[1]),
      .i2s_data(dat[1]), .frame_start(fs[1]), .underrun(ur[1]));

   always #5 clk = ~clk;

   // reference model state
   int          n [2];
   bit          mhf [2];
   logic [15:0] mhl [2], mhr [2], mcl [2], mcr [2];
   bit          ews [2], edat [2], efs [2], eur [2], acc [2];
   // receiver state
   logic [63:0] sr [2], lw [2], rw [2];
   bit          pb [2], pws [2];

   int n_cmp = 0;
   int n_bad = 0;
   int fs_cnt0 = 0, ur_cnt0 = 0, ur_alone0 = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int slot(input int i);
      return (i == 0) ? 16 : 24;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         n[i] = 0; mhf[i] = 0; mhl[i] = '0; mhr[i] = '0; mcl[i] = '0; mcr[i] = '0;
         ews[i] = 0; edat[i] = 0; efs[i] = 0; eur[i] = 0; acc[i] = 0;
         sr[i] = '0; lw[i] = '0; rw[i] = '0; pb[i] = 0; pws[i] = 0;
      end
   endtask

   // One clk of the frame model: bit k (k-th BCLK fall) sits at position (k-1) mod 2W.
   task automatic model_step(input int i);
      int w, p, s;
      logic [15:0] word;
      w = slot(i);
      efs[i] = 0; eur[i] = 0; acc[i] = 0;
      if (!reset_n) return;
      acc[i] = vld[i] && !mhf[i];
      if (!en) begin
         n[i] = 0; ews[i] = 0; edat[i] = 0;
      end else begin
         n[i]++;
         if (n[i] % (2 * CD) == 0) begin
            p = (n[i] / (2 * CD) - 1) % (2 * w);
            if (p == 0) begin
               efs[i] = 1;
               if (mhf[i]) begin
                  mcl[i] = mhl[i]; mcr[i] = mhr[i]; mhf[i] = 0;
               end else begin
                  eur[i] = 1;
               end
            end
            ews[i] = (p >= w - 1) && (p <= 2 * w - 2);
            s = (p < w) ? p : p - w;
            word = (p < w) ? mcl[i] : mcr[i];
            edat[i] = (s < SW) ? word[SW-1-s] : 1'b0;
         end
      end
      if (acc[i]) begin
         mhl[i] = in_l; mhr[i] = in_r; mhf[i] = 1;
      end
   endtask

   task automatic check_outs(input int i);
      bit eb;
      eb = ((n[i] / CD) % 2) == 1;
      chk($sformatf("bclk%0d", i), 64'(bclk[i]), 64'(eb));
      chk($sformatf("ws%0d", i), 64'(ws[i]), 64'(ews[i]));
      chk($sformatf("data%0d", i), 64'(dat[i]), 64'(edat[i]));
      chk($sformatf("frame_start%0d", i), 64'(fs[i]), 64'(efs[i]));
      chk($sformatf("underrun%0d", i), 64'(ur[i]), 64'(eur[i]));
      chk($sformatf("in_ready%0d", i), 64'(rdy[i]), 64'(!mhf[i]));
   endtask

   // Latch on BCLK rise; a WS change marks the current bit as the LSB of the old channel.
   task automatic receive(input int i);
      logic [63:0] mask;
      mask = (64'd1 << slot(i)) - 64'd1;
      if (!pb[i] && bclk[i]) begin
         sr[i] = {sr[i][62:0], dat[i]};
         if (ws[i] != pws[i]) begin
            if (!pws[i]) lw[i] = sr[i] & mask;
            else         rw[i] = sr[i] & mask;
         end
         pws[i] = ws[i];
      end
      pb[i] = bclk[i];
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check_outs(i);
         receive(i);
      end
      if (fs[0]) fs_cnt0++;
      if (ur[0]) ur_cnt0++;
      if (ur[0] && !fs[0]) ur_alone0++;
   endtask

   task automatic push(input int i, input logic [15:0] l, input logic [15:0] r);
      int t;
      in_l = l; in_r = r; vld[i] = 1'b1; t = 0;
      do begin
         tick();
         t++;
      end while (!acc[i] && t < 1000);
      vld[i] = 1'b0;
      chk("push_timeout", 64'(t < 1000), 64'(1));
      in_l = 16'($urandom); in_r = 16'($urandom);
   endtask

   // Asynchronous reset applied between edges; outputs must clear before the next edge.
   task automatic do_reset(input int cycles);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_bclk%0d", i), 64'(bclk[i]), 64'(0));
         chk($sformatf("rst_ws%0d", i), 64'(ws[i]), 64'(0));
         chk($sformatf("rst_data%0d", i), 64'(dat[i]), 64'(0));
         chk($sformatf("rst_fs%0d", i), 64'(fs[i]), 64'(0));
         chk($sformatf("rst_ur%0d", i), 64'(ur[i]), 64'(0));
         chk($sformatf("rst_rdy%0d", i), 64'(rdy[i]), 64'(1));
      end
      repeat (cycles) tick();
      reset_n = 1'b1;
   endtask

   initial begin
      int t;
      model_reset();
      @(negedge clk);
      do_reset(3);

      // Single pair on 16-bit slots, padded pair on 24-bit slots.
      en = 1'b1;
      push(0, 16'hA5F0, 16'h0F0F);
      push(1, 16'h8001, 16'h00FF);
      repeat (200) tick();
      chk("rx_left0", lw[0], 64'h0000_A5F0);
      chk("rx_right0", rw[0], 64'h0000_0F0F);
      chk("rx_left1_pad", lw[1], 64'h0080_0100);
      chk("rx_right1_pad", rw[1], 64'h0000_FF00);

      // Underrun: two frames of repeats, one pulse per frame start.
      fs_cnt0 = 0; ur_cnt0 = 0; ur_alone0 = 0;
      repeat (256) tick();
      chk("underrun_cnt", 64'(ur_cnt0), 64'(2));
      chk("frame_cnt", 64'(fs_cnt0), 64'(2));
      chk("underrun_alone", 64'(ur_alone0), 64'(0));
      chk("rx_repeat_left0", lw[0], 64'h0000_A5F0);

      // Soft stop mid-frame with a pair accepted while stopped.
      repeat (37) tick();
      en = 1'b0;
      push(0, 16'hC3A5, 16'h5A3C);
      repeat (49) tick();
      en = 1'b1;
      t = 0;
      do begin
         tick();
         t++;
      end while (!fs[0] && t < 20);
      chk("reen_latency", 64'(t), 64'(2 * CD));
      chk("reen_msb", 64'(dat[0]), 64'(1));
      chk("reen_ur", 64'(ur[0]), 64'(0));

      // Back-pressure: second pair waits for the first to load.
      repeat (60) tick();
      push(0, 16'h1234, 16'h5678);
      push(0, 16'h9ABC, 16'hDEF0);
      ur_cnt0 = 0;
      repeat (200) tick();
      chk("bp_no_underrun", 64'(ur_cnt0), 64'(0));
      repeat (60) tick();
      chk("bp_left0", lw[0], 64'h0000_9ABC);
      chk("bp_right0", rw[0], 64'h0000_DEF0);

      // Random traffic with occasional stops.
      for (int it = 0; it < 30; it++) begin
         repeat ($urandom_range(0, 150)) tick();
         if ($urandom_range(0, 4) == 0) begin
            en = 1'b0;
            repeat ($urandom_range(1, 60)) tick();
            en = 1'b1;
         end
         push(int'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      end
      repeat (300) tick();

      do_reset(4);
      repeat (100) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
